// File: rtl/led_nios_pkg.sv
// Shared types and constants for the sysid read arbiter.
// The sysid slave has two words: a fixed ID word and a build timestamp word.
package led_nios_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int DEFAULT_DATA_W = 32;

endpackage

// File: rtl/led_nios_rr_arbiter.sv
// Combinational round-robin pick: the first requester found at or after
// last_grant+1, wrapping modulo NUM_REQ.
module led_nios_rr_arbiter
  import led_nios_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]                        req,
  input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] last_grant,
  output logic [NUM_REQ-1:0]                        grant_onehot,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_index
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_onehot = '0;
    grant_index  = '0;
    found        = 1'b0;
    cand         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found              = 1'b1;
        grant_onehot[cand] = 1'b1;
        grant_index        = cand;
      end
    end
  end

endmodule

// File: rtl/led_nios_sysid_arbiter.sv
// Serializes reads from NUM_REQ masters onto the single sysid slave:
// IDLE arbitrates, ISSUE accepts and captures, RESP returns readdatavalid.
module led_nios_sysid_arbiter
  import led_nios_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_read,
  input  logic [NUM_REQ-1:0] req_address,
  output logic [NUM_REQ-1:0] req_waitrequest,
  output logic [NUM_REQ-1:0] req_readdatavalid,
  output logic [DATA_W-1:0]  req_readdata,
  output logic               sysid_address,
  input  logic [DATA_W-1:0]  sysid_readdata,
  output logic               busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   grant_reg;
  logic [PTR_W-1:0]   last_grant_reg;
  logic [NUM_REQ-1:0] grant_oh_reg;
  logic [DATA_W-1:0]  readdata_reg;
  logic               sysid_address_reg;
  logic [PTR_W-1:0]   pick_index;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               any_req;

  assign any_req = |req_read;

  led_nios_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req          (req_read),
    .last_grant   (last_grant_reg),
    .grant_onehot (pick_onehot),
    .grant_index  (pick_index)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = any_req ? ISSUE : IDLE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset starts with last_grant at the top index so requester 0 wins first.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg         <= IDLE;
      grant_reg         <= '0;
      grant_oh_reg      <= '0;
      last_grant_reg    <= PTR_W'(NUM_REQ - 1);
      readdata_reg      <= '0;
      sysid_address_reg <= SYSID_ADDR_ID;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_reg         <= pick_index;
            grant_oh_reg      <= pick_onehot;
            sysid_address_reg <= req_address[pick_index];
          end
        end
        ISSUE: begin
          readdata_reg   <= sysid_readdata;
          last_grant_reg <= grant_reg;
        end
        RESP: begin
          sysid_address_reg <= SYSID_ADDR_ID;
        end
        default: ;
      endcase
    end
  end

  // Waitrequest follows the strobe, so an idle requester is never stalled.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_waitrequest[gi]   = req_read[gi] &
                                     ~((state_reg == ISSUE) & grant_oh_reg[gi]);
      assign req_readdatavalid[gi] = (state_reg == RESP) & grant_oh_reg[gi];
    end
  endgenerate

  assign req_readdata  = readdata_reg;
  assign sysid_address = sysid_address_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_led_nios_sysid_arbiter.sv
// Directed and random reads against a transaction-level model of the arbiter.
module tb_led_nios_sysid_arbiter;
  import led_nios_pkg::*;

  localparam int N  = 2;
  localparam int DW = 32;
  localparam logic [DW-1:0] TS_WORD = 32'h5F17_8F7B;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req_read;
  logic [N-1:0]  req_address;
  logic [N-1:0]  req_waitrequest;
  logic [N-1:0]  req_readdatavalid;
  logic [DW-1:0] req_readdata;
  logic          sysid_address;
  logic [DW-1:0] sysid_readdata;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  // Model: phase 0 = no transfer, 1 = accept cycle, 2 = data-valid cycle.
  int            m_phase;
  int            m_owner;
  int            m_last;
  logic          m_addr;
  logic [DW-1:0] m_data;
  logic [N-1:0]  m_accepted;

  always #5 clock = ~clock;

  assign sysid_readdata = (sysid_address == SYSID_ADDR_TS) ? TS_WORD : '0;

  led_nios_sysid_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clock             (clock),
    .reset             (reset),
    .req_read          (req_read),
    .req_address       (req_address),
    .req_waitrequest   (req_waitrequest),
    .req_readdatavalid (req_readdatavalid),
    .req_readdata      (req_readdata),
    .sysid_address     (sysid_address),
    .sysid_readdata    (sysid_readdata),
    .busy              (busy)
  );

  function automatic logic [DW-1:0] slave_word(input logic a);
    return a ? TS_WORD : '0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [N-1:0] e_wait, e_valid;
    for (int i = 0; i < N; i++) begin
      e_wait[i]  = req_read[i] && !(m_phase == 1 && m_owner == i);
      e_valid[i] = (m_phase == 2 && m_owner == i);
    end
    chk("busy", 64'(busy), 64'(m_phase != 0));
    chk("waitrequest", 64'(req_waitrequest), 64'(e_wait));
    chk("readdatavalid", 64'(req_readdatavalid), 64'(e_valid));
    chk("readdata", 64'(req_readdata), 64'(m_data));
    chk("sysid_address", 64'(sysid_address), 64'((m_phase != 0) ? m_addr : 1'b0));
  endtask

  task automatic model_step();
    m_accepted = '0;
    if (reset) begin
      m_phase = 0;
      m_last  = N - 1;
      m_data  = '0;
      m_addr  = 1'b0;
    end else begin
      case (m_phase)
        0: if (req_read != '0) begin
          for (int k = 1; k <= N; k++) begin
            if (req_read[(m_last + k) % N]) begin
              m_owner = (m_last + k) % N;
              break;
            end
          end
          m_addr  = req_address[m_owner];
          m_phase = 1;
        end
        1: begin
          m_data               = slave_word(m_addr);
          m_last               = m_owner;
          m_accepted[m_owner]  = 1'b1;
          m_phase              = 2;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  // Check the current cycle mid-period, then advance the model on the edge.
  task automatic cycle();
    @(negedge clock);
    check_model();
    @(posedge clock);
    model_step();
    #1;
  endtask

  initial begin
    int cnt0, cnt1;
    reset       = 1'b1;
    req_read    = '0;
    req_address = '0;
    m_owner     = 0;
    repeat (2) begin
      @(posedge clock);
      model_step();
      #1;
    end
    cycle();
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_readdata", 64'(req_readdata), 64'(0));
    reset = 1'b0;

    // Single read of the timestamp word by requester 0.
    req_read = 2'b01; req_address = 2'b01;
    cycle();
    chk("single_accept", 64'(req_waitrequest), 64'(0));
    chk("single_busy_c1", 64'(busy), 64'(1));
    cycle();
    chk("single_valid", 64'(req_readdatavalid), 64'(2'b01));
    chk("single_data", 64'(req_readdata), 64'(TS_WORD));
    req_read = '0;
    cycle();
    chk("single_idle", 64'(busy), 64'(0));

    // Contention right after reset: requester 0 first, requester 1 stalled.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    req_read = 2'b11; req_address = 2'b10;
    cycle();
    chk("cont_wait_c1", 64'(req_waitrequest), 64'(2'b10));
    cycle();
    chk("cont_valid0", 64'(req_readdatavalid), 64'(2'b01));
    chk("cont_data0", 64'(req_readdata), 64'(0));
    req_read[0] = 1'b0;
    cycle();
    chk("cont_wait_c3", 64'(req_waitrequest), 64'(2'b10));
    cycle();
    chk("cont_accept1", 64'(req_waitrequest), 64'(0));
    cycle();
    chk("cont_valid1", 64'(req_readdatavalid), 64'(2'b10));
    chk("cont_data1", 64'(req_readdata), 64'(TS_WORD));
    req_read = '0;
    cycle();

    // Fairness: both requesters hold read for eight transactions.
    req_read = 2'b11; req_address = 2'b01;
    cnt0 = 0; cnt1 = 0;
    repeat (24) begin
      cycle();
      cnt0 += int'(req_readdatavalid[0]);
      cnt1 += int'(req_readdatavalid[1]);
    end
    req_read = '0;
    chk("fair_cnt0", 64'(cnt0), 64'(4));
    chk("fair_cnt1", 64'(cnt1), 64'(4));
    cycle();

    // Reset while requester 1 is in ISSUE; requester 0 must win afterwards.
    req_read = 2'b11; req_address = 2'b11;
    repeat (4) cycle();
    chk("rst_issue1", 64'(req_waitrequest), 64'(2'b01));
    reset = 1'b1;
    cycle();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(req_readdatavalid), 64'(0));
    chk("rst_data", 64'(req_readdata), 64'(0));
    reset = 1'b0;
    cycle();
    chk("rst_regrant0", 64'(req_waitrequest), 64'(2'b10));
    cycle();
    req_read = '0;
    repeat (2) cycle();

    // Read dropped during ISSUE still completes.
    req_read = 2'b01; req_address = 2'b01;
    cycle();
    req_read = '0;
    cycle();
    chk("drop_valid", 64'(req_readdatavalid), 64'(2'b01));

    // Idle hold.
    repeat (10) cycle();
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_wait", 64'(req_waitrequest), 64'(0));
    chk("idle_addr", 64'(sysid_address), 64'(0));
    chk("idle_hold", 64'(req_readdata), 64'(TS_WORD));

    // Random well-behaved requesters with occasional resets.
    for (int c = 0; c < 400; c++) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        if (m_accepted[i]) begin
          req_read[i] = 1'b0;
        end else if (!req_read[i] && $urandom_range(0, 2) == 0) begin
          req_read[i]    = 1'b1;
          req_address[i] = 1'($urandom_range(0, 1));
        end
      end
      reset = ($urandom_range(0, 99) == 0);
    end
    reset = 1'b0;
    req_read = '0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
